bt_cmd_parser: RTL and testbench

BT_CMD_PARSER -- requirements
Module: bt_cmd_parser

---
 rtl/bt_pkg.sv | 26 ++
 rtl/hex_nibble_dec.sv | 22 ++
 rtl/bt_cmd_parser.sv | 150 +++++++++++++++
 tb/tb_bt_cmd_parser.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth command-frame parser:
// FSM state encoding, framing characters and error-cause codes.
package bt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_HEX_HI,
      ST_HEX_LO,
      ST_TERM
   } state_e;

   localparam logic [7:0] ASCII_DOLLAR = 8'h24;
   localparam logic [7:0] ASCII_CR     = 8'h0D;
   localparam logic [7:0] ASCII_LF     = 8'h0A;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
   localparam logic [1:0] ERR_BAD_TERM = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   function automatic logic is_cmd_letter(input logic [7:0] c);
      return (c >= 8'h41) && (c <= 8'h5A);
   endfunction

endpackage

// File: rtl/hex_nibble_dec.sv
// ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' -> {valid, nibble}.
module hex_nibble_dec (
   input  logic [7:0] ascii,
   output logic       valid,
   output logic [3:0] nibble
);

   always_comb begin
      valid  = 1'b0;
      nibble = '0;
      if ((ascii >= 8'h30) && (ascii <= 8'h39)) begin
         valid  = 1'b1;
         nibble = ascii[3:0];
      end else if (((ascii >= 8'h41) && (ascii <= 8'h46)) ||
                   ((ascii >= 8'h61) && (ascii <= 8'h66))) begin
         // Low nibble of 'A'/'a' is 1, so +9 yields 10..15.
         valid  = 1'b1;
         nibble = ascii[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/bt_cmd_parser.sv
// Parses "$<A-Z><hex><hex><CR|LF>" frames from a byte stream into a
// registered command/argument pair, with error reporting and inter-byte timeout.
module bt_cmd_parser
   import bt_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic       clk_10Hz,
   input  logic       reset,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic       cmd_valid,
   output logic [7:0] cmd_code,
   output logic [7:0] cmd_arg,
   output logic       err,
   output logic [1:0] err_code,
   output logic [7:0] frame_cnt
);

   localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYC - 1);

   state_e      state_q, state_d;
   logic [23:0] to_cnt_q, to_cnt_d;
   logic [7:0]  code_tmp_q, code_tmp_d;
   logic [7:0]  arg_tmp_q, arg_tmp_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_code_q, cmd_code_d;
   logic [7:0]  cmd_arg_q, cmd_arg_d;
   logic        err_q, err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;

   logic        hex_valid;
   logic [3:0]  hex_nib;

   hex_nibble_dec u_hex (
      .ascii  (rx_byte),
      .valid  (hex_valid),
      .nibble (hex_nib)
   );

   always_comb begin
      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      code_tmp_d  = code_tmp_q;
      arg_tmp_d   = arg_tmp_q;
      cmd_valid_d = 1'b0;
      cmd_code_d  = cmd_code_q;
      cmd_arg_d   = cmd_arg_q;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      frame_cnt_d = frame_cnt_q;

      if (rx_valid || (state_q == ST_IDLE)) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != '1) begin
         to_cnt_d = to_cnt_q + 24'd1;
      end

      // A byte always takes priority over a coincident timeout expiry.
      if (rx_valid) begin
         if ((state_q != ST_IDLE) && (rx_byte == ASCII_DOLLAR)) begin
            state_d = ST_CMD;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (rx_byte == ASCII_DOLLAR) state_d = ST_CMD;
               end
               ST_CMD: begin
                  if (is_cmd_letter(rx_byte)) begin
                     code_tmp_d = rx_byte;
                     state_d    = ST_HEX_HI;
                  end else begin
                     err_d      = 1'b1;
                     err_code_d = ERR_BAD_CHAR;
                     state_d    = ST_IDLE;
                  end
               end
               ST_HEX_HI, ST_HEX_LO: begin
                  if (hex_valid) begin
                     if (state_q == ST_HEX_HI) begin
                        arg_tmp_d = {hex_nib, arg_tmp_q[3:0]};
                        state_d   = ST_HEX_LO;
                     end else begin
                        arg_tmp_d = {arg_tmp_q[7:4], hex_nib};
                        state_d   = ST_TERM;
                     end
                  end else begin
                     err_d      = 1'b1;
                     err_code_d = ERR_BAD_CHAR;
                     state_d    = ST_IDLE;
                  end
               end
               ST_TERM: begin
                  if ((rx_byte == ASCII_CR) || (rx_byte == ASCII_LF)) begin
                     cmd_code_d  = code_tmp_q;
                     cmd_arg_d   = arg_tmp_q;
                     cmd_valid_d = 1'b1;
                     frame_cnt_d = frame_cnt_q + 8'd1;
                  end else begin
                     err_d      = 1'b1;
                     err_code_d = ERR_BAD_TERM;
                  end
                  state_d = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end else if ((state_q != ST_IDLE) && (to_cnt_q == TO_LAST)) begin
         err_d      = 1'b1;
         err_code_d = ERR_TIMEOUT;
         state_d    = ST_IDLE;
         to_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_10Hz or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         to_cnt_q    <= '0;
         code_tmp_q  <= '0;
         arg_tmp_q   <= '0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= '0;
         cmd_arg_q   <= '0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         code_tmp_q  <= code_tmp_d;
         arg_tmp_q   <= arg_tmp_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
         cmd_arg_q   <= cmd_arg_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = cmd_code_q;
   assign cmd_arg   = cmd_arg_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Scoreboard bench for bt_cmd_parser: expected cmd/err events are queued as
// bytes are driven and matched, cycle-exact, against the DUT output pulses.
`timescale 1ns/1ps
module tb_bt_cmd_parser;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       cmd_valid, err;
   logic [7:0] cmd_code, cmd_arg, frame_cnt;
   logic [1:0] err_code;

   logic       s_rx_valid;
   logic [7:0] s_rx_byte;
   logic       s_cmd_valid, s_err;
   logic [7:0] s_cmd_code, s_cmd_arg, s_frame_cnt;
   logic [1:0] s_err_code;

   always #50 clk = ~clk;

   bt_cmd_parser #(.TIMEOUT_CYC(100)) dut (
      .clk_10Hz (clk),
      .reset    (reset_n),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .cmd_valid(cmd_valid),
      .cmd_code (cmd_code),
      .cmd_arg  (cmd_arg),
      .err      (err),
      .err_code (err_code),
      .frame_cnt(frame_cnt)
   );

   // Default (long) timeout instance for the slow-rate frame.
   bt_cmd_parser dut_slow (
      .clk_10Hz (clk),
      .reset    (reset_n),
      .rx_byte  (s_rx_byte),
      .rx_valid (s_rx_valid),
      .cmd_valid(s_cmd_valid),
      .cmd_code (s_cmd_code),
      .cmd_arg  (s_cmd_arg),
      .err      (s_err),
      .err_code (s_err_code),
      .frame_cnt(s_frame_cnt)
   );

   typedef struct {
      bit          is_err;
      int unsigned edge_n;
      logic [7:0]  code;
      logic [7:0]  arg;
      logic [1:0]  ecode;
      logic [7:0]  cnt;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;
   int unsigned last_edge = 0;
   logic [7:0]  exp_cnt   = '0;
   logic [7:0]  exp_code  = '0;
   logic [7:0]  exp_arg   = '0;
   logic [1:0]  exp_ecode = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Byte is set up at a falling edge and sampled on the following rising edge.
   task automatic put_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte   = b;
      rx_valid  = 1'b1;
      last_edge = cyc + 1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic push_cmd(input logic [7:0] code, input logic [7:0] arg);
      exp_cnt  = exp_cnt + 8'd1;
      exp_code = code;
      exp_arg  = arg;
      sb.push_back('{1'b0, last_edge, code, arg, exp_ecode, exp_cnt});
   endtask

   task automatic push_err(input logic [1:0] ec, input int unsigned edge_n);
      exp_ecode = ec;
      sb.push_back('{1'b1, edge_n, exp_code, exp_arg, ec, exp_cnt});
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && (cmd_valid || err)) begin
            total++;
            if (cmd_valid && err) begin
               bad++;
               $display("FAIL both_pulses at edge %0d: cmd_valid=1 err=1, required exclusive", cyc);
            end else if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_event at edge %0d: cmd_valid=%0b err=%0b, required none",
                        cyc, cmd_valid, err);
            end else begin
               e = sb.pop_front();
               if (err !== e.is_err || cyc !== e.edge_n || cmd_code !== e.code ||
                   cmd_arg !== e.arg || err_code !== e.ecode || frame_cnt !== e.cnt) begin
                  bad++;
                  $display("FAIL event got err=%0b edge=%0d code=%h arg=%h ecode=%0d cnt=%0d; required err=%0b edge=%0d code=%h arg=%h ecode=%0d cnt=%0d",
                           err, cyc, cmd_code, cmd_arg, err_code, frame_cnt,
                           e.is_err, e.edge_n, e.code, e.arg, e.ecode, e.cnt);
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset_n = 1'b0;
      rx_valid = 1'b0; rx_byte = '0;
      s_rx_valid = 1'b0; s_rx_byte = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({cmd_valid, err, cmd_code, cmd_arg, err_code, frame_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_values got v=%0b e=%0b code=%h arg=%h ec=%0d cnt=%0d, required all 0",
                  cmd_valid, err, cmd_code, cmd_arg, err_code, frame_cnt);
      end
      reset_n = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_slow_frame();
      logic [7:0] msg [5] = '{8'h24, 8'h4C, 8'h33, 8'h46, 8'h0D};
      int n_cmd = 0;
      int n_err = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s_rx_byte  = msg[i];
         s_rx_valid = 1'b1;
         repeat (1040) begin
            @(negedge clk);
            s_rx_valid = 1'b0;
            if (s_cmd_valid) n_cmd++;
            if (s_err) n_err++;
         end
      end
      total++;
      if (n_cmd !== 1 || n_err !== 0) begin
         bad++;
         $display("FAIL slow_pulses got cmd=%0d err=%0d, required cmd=1 err=0", n_cmd, n_err);
      end
      total++;
      if (s_cmd_code !== 8'h4C || s_cmd_arg !== 8'h3F || s_frame_cnt !== 8'd1) begin
         bad++;
         $display("FAIL slow_fields got code=%h arg=%h cnt=%0d, required 4c 3f 1",
                  s_cmd_code, s_cmd_arg, s_frame_cnt);
      end
   endtask

   task automatic test_spaced();
      logic [7:0] msg [5] = '{8'h24, 8'h4C, 8'h33, 8'h46, 8'h0D};
      for (int i = 0; i < 5; i++) begin
         put_byte(msg[i]);
         if (i == 4) push_cmd(8'h4C, 8'h3F);
         idle_cycles(3);
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL spaced_drain pending=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] msg [5] = '{8'h24, 8'h4D, 8'h61, 8'h37, 8'h0A};
      for (int i = 0; i < 5; i++) put_byte(msg[i]);
      push_cmd(8'h4D, 8'hA7);
      idle_cycles(4);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL b2b_drain pending=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_bad_char();
      logic [7:0] msg [8] = '{8'h24, 8'h4C, 8'h47, 8'h30, 8'h0D, 8'h78, 8'h79, 8'h0D};
      for (int i = 0; i < 8; i++) begin
         put_byte(msg[i]);
         if (i == 2) push_err(2'd1, last_edge);
      end
      idle_cycles(4);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL badchar_drain pending=%0d required=0", sb.size());
         sb.delete();
      end
      total++;
      if (cmd_code !== exp_code || cmd_arg !== exp_arg || err_code !== 2'd1) begin
         bad++;
         $display("FAIL badchar_hold got code=%h arg=%h ec=%0d, required %h %h 1",
                  cmd_code, cmd_arg, err_code, exp_code, exp_arg);
      end
   endtask

   task automatic test_bad_term();
      logic [7:0] msg [5] = '{8'h24, 8'h41, 8'h31, 8'h32, 8'h58};
      for (int i = 0; i < 5; i++) put_byte(msg[i]);
      push_err(2'd2, last_edge);
      idle_cycles(4);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL badterm_drain pending=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_timeout();
      int unsigned e;
      put_byte(8'h24); put_byte(8'h4C); put_byte(8'h31);
      push_err(2'd3, last_edge + 100);
      idle_cycles(130);
      // Second frame: next byte lands exactly on the expiry edge and must win.
      put_byte(8'h24); put_byte(8'h4C); put_byte(8'h31);
      e = last_edge;
      idle_cycles(99);
      put_byte(8'h32);
      total++;
      if (last_edge !== e + 100) begin
         bad++;
         $display("FAIL timeout_setup got edge=%0d required=%0d", last_edge, e + 100);
      end
      put_byte(8'h0D);
      push_cmd(8'h4C, 8'h12);
      idle_cycles(130);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL timeout_drain pending=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_resync();
      logic [7:0] msg [7] = '{8'h24, 8'h4C, 8'h24, 8'h50, 8'h30, 8'h35, 8'h0D};
      for (int i = 0; i < 7; i++) put_byte(msg[i]);
      push_cmd(8'h50, 8'h05);
      idle_cycles(4);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL resync_drain pending=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_wrap();
      logic [7:0] msg [5] = '{8'h24, 8'h4B, 8'h66, 8'h30, 8'h0D};
      int n = 256 - int'(exp_cnt);
      for (int f = 0; f < n; f++) begin
         for (int i = 0; i < 5; i++) put_byte(msg[i]);
         push_cmd(8'h4B, 8'hF0);
      end
      idle_cycles(4);
      total++;
      if (frame_cnt !== 8'h00 || sb.size() != 0) begin
         bad++;
         $display("FAIL wrap got cnt=%0d pending=%0d, required cnt=0 pending=0", frame_cnt, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] msg [7] = '{8'h30, 8'h0D, 8'h24, 8'h41, 8'h30, 8'h30, 8'h0D};
      put_byte(8'h24); put_byte(8'h41); put_byte(8'h31);
      idle_cycles(1);
      reset_n = 1'b0;
      #1;
      total++;
      if ({cmd_valid, err, cmd_code, cmd_arg, err_code, frame_cnt} !== '0) begin
         bad++;
         $display("FAIL midreset_async got code=%h arg=%h ec=%0d cnt=%0d, required all 0",
                  cmd_code, cmd_arg, err_code, frame_cnt);
      end
      idle_cycles(3);
      total++;
      if ({cmd_valid, err, cmd_code, cmd_arg, err_code, frame_cnt} !== '0) begin
         bad++;
         $display("FAIL midreset_hold got code=%h arg=%h ec=%0d cnt=%0d, required all 0",
                  cmd_code, cmd_arg, err_code, frame_cnt);
      end
      reset_n = 1'b1;
      exp_cnt = '0; exp_code = '0; exp_arg = '0; exp_ecode = '0;
      idle_cycles(2);
      for (int i = 0; i < 7; i++) put_byte(msg[i]);
      push_cmd(8'h41, 8'h00);
      idle_cycles(4);
      total++;
      if (sb.size() != 0 || cmd_code !== 8'h41 || frame_cnt !== 8'd1) begin
         bad++;
         $display("FAIL midreset_frame got code=%h cnt=%0d pending=%0d, required 41 1 0",
                  cmd_code, frame_cnt, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      test_reset();
      test_slow_frame();
      test_spaced();
      test_back_to_back();
      test_bad_char();
      test_bad_term();
      test_timeout();
      test_resync();
      test_wrap();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
